// File: rtl/writeback_queue_pkg.sv
// Shared types and constants for the writeback queue.
//   RegIdxW / DataW : register-index and data widths of the write port
//   wb_entry_t      : one queued register-file write (destination + data)
//   prio_e          : round-robin priority owner (producer A or B)
package writeback_queue_pkg;

    localparam int unsigned RegIdxW = 5;
    localparam int unsigned DataW   = 32;

    typedef logic [RegIdxW-1:0] reg_idx_t;
    typedef logic [DataW-1:0]   data_t;

    typedef struct packed {
        reg_idx_t rd;
        data_t    data;
    } wb_entry_t;

    typedef enum logic {
        PrioA = 1'b0,
        PrioB = 1'b1
    } prio_e;

endpackage

// File: rtl/writeback_arbiter.sv
// Two-way round-robin arbiter with a registered priority bit.
//   clk_i              : clock
//   rst_ni             : synchronous active-low reset (priority returns to A)
//   en_i               : a grant may be issued this cycle (queue not full, not in reset)
//   valid_a_i/valid_b_i: requests from producer A / B
//   grant_a_o/grant_b_o: one-hot (or zero) grant
module writeback_arbiter
    import writeback_queue_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic valid_a_i,
    input  logic valid_b_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    prio_e prio_q, prio_d;

    always_comb begin
        grant_a_o = 1'b0;
        grant_b_o = 1'b0;
        prio_d    = prio_q;
        if (en_i) begin
            if (valid_a_i && valid_b_i) begin
                // Contested: the current owner wins, priority passes to the loser.
                if (prio_q == PrioA) begin
                    grant_a_o = 1'b1;
                    prio_d    = PrioB;
                end else begin
                    grant_b_o = 1'b1;
                    prio_d    = PrioA;
                end
            end else begin
                grant_a_o = valid_a_i;
                grant_b_o = valid_b_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_q <= PrioA;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU (A) and LSU (B) results into one register-file
// write port through an in-order FIFO, with pending-write forwarding.
//   i_Clock, i_Reset          : clock, synchronous active-low reset
//   i_ValidA/B, i_RDA/B, i_DA/B: producer results; o_ReadyA/B accept strobes
//   i_Stall                   : register-file write port busy this cycle
//   o_WriteEnable, o_RD, o_D  : register-file write port (head of queue)
//   i_QueryRS, o_FwdHit/Data  : youngest pending write to i_QueryRS
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic               i_ValidA,
    input  logic               i_ValidB,
    input  logic [RegIdxW-1:0] i_RDA,
    input  logic [RegIdxW-1:0] i_RDB,
    input  logic [DataW-1:0]   i_DA,
    input  logic [DataW-1:0]   i_DB,
    output logic               o_ReadyA,
    output logic               o_ReadyB,
    input  logic               i_Stall,
    output logic               o_WriteEnable,
    output logic [RegIdxW-1:0] o_RD,
    output logic [DataW-1:0]   o_D,
    input  logic [RegIdxW-1:0] i_QueryRS,
    output logic               o_FwdHit,
    output logic [DataW-1:0]   o_FwdData
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic      arb_en, grant_a, grant_b;
    wb_entry_t in_entry, head;
    logic      has_data, enq, deq;

    // Readiness looks only at registered occupancy, so a same-cycle dequeue
    // never opens a slot for a producer.
    assign arb_en = i_Reset && (count_q != CntFull);

    writeback_arbiter u_arbiter (
        .clk_i     (i_Clock),
        .rst_ni    (i_Reset),
        .en_i      (arb_en),
        .valid_a_i (i_ValidA),
        .valid_b_i (i_ValidB),
        .grant_a_o (grant_a),
        .grant_b_o (grant_b)
    );

    assign o_ReadyA = grant_a;
    assign o_ReadyB = grant_b;

    always_comb begin
        in_entry.rd   = grant_a ? i_RDA : i_RDB;
        in_entry.data = grant_a ? i_DA  : i_DB;
    end

    // Writes to x0 are acknowledged but dropped.
    assign enq = (grant_a || grant_b) && (in_entry.rd != '0);

    assign has_data      = (count_q != '0);
    assign head          = mem_q[rd_ptr_q];
    // Gated by reset so a pending head is never written during a reset cycle.
    assign o_WriteEnable = has_data && !i_Stall && i_Reset;
    assign deq           = o_WriteEnable;
    assign o_RD          = has_data ? head.rd   : '0;
    assign o_D           = has_data ? head.data : '0;

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q + CntW'(enq) - CntW'(deq);
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy is tracked by count_q alone.
    always_ff @(posedge i_Clock) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    // Walk oldest to youngest so the last match is the youngest pending write.
    logic [PtrW-1:0] idx;
    always_comb begin
        o_FwdHit  = 1'b0;
        o_FwdData = '0;
        idx       = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PtrW'(k);
            if ((CntW'(k) < count_q) && (i_QueryRS != '0) && (mem_q[idx].rd == i_QueryRS)) begin
                o_FwdHit  = 1'b1;
                o_FwdData = mem_q[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (DEPTH = 4): reset behaviour, single
// transfer latency, round-robin alternation, full/stall handling,
// forwarding, x0 drop and mid-operation reset.
module tb_writeback_queue;

    logic        i_Clock;
    logic        i_Reset;
    logic        i_ValidA, i_ValidB;
    logic [4:0]  i_RDA, i_RDB;
    logic [31:0] i_DA, i_DB;
    logic        o_ReadyA, o_ReadyB;
    logic        i_Stall;
    logic        o_WriteEnable;
    logic [4:0]  o_RD;
    logic [31:0] o_D;
    logic [4:0]  i_QueryRS;
    logic        o_FwdHit;
    logic [31:0] o_FwdData;

    int n_checks = 0;
    int n_fails  = 0;

    writeback_queue #(.DEPTH(4)) dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .i_ValidA      (i_ValidA),
        .i_ValidB      (i_ValidB),
        .i_RDA         (i_RDA),
        .i_RDB         (i_RDB),
        .i_DA          (i_DA),
        .i_DB          (i_DB),
        .o_ReadyA      (o_ReadyA),
        .o_ReadyB      (o_ReadyB),
        .i_Stall       (i_Stall),
        .o_WriteEnable (o_WriteEnable),
        .o_RD          (o_RD),
        .o_D           (o_D),
        .i_QueryRS     (i_QueryRS),
        .o_FwdHit      (o_FwdHit),
        .o_FwdData     (o_FwdData)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    initial begin
        i_Reset   = 1'b0;
        i_ValidA  = 1'b1;
        i_ValidB  = 1'b0;
        i_RDA     = 5'd9;
        i_RDB     = 5'd0;
        i_DA      = 32'h0;
        i_DB      = 32'h0;
        i_Stall   = 1'b0;
        i_QueryRS = 5'd9;

        // Reset held two edges; ready must stay low even with a valid request.
        tick();
        @(negedge i_Clock);
        chk("rst_we",      32'(o_WriteEnable), 32'd0);
        chk("rst_ready_a", 32'(o_ReadyA),      32'd0);
        chk("rst_ready_b", 32'(o_ReadyB),      32'd0);
        chk("rst_hit",     32'(o_FwdHit),      32'd0);
        chk("rst_rd",      32'(o_RD),          32'd0);
        chk("rst_d",       o_D,                32'd0);
        chk("rst_fwd",     o_FwdData,          32'd0);
        tick();

        // Single transfer, one-cycle latency.
        i_Reset   = 1'b1;
        i_ValidA  = 1'b1;
        i_RDA     = 5'd5;
        i_DA      = 32'h1234;
        i_QueryRS = 5'd0;
        @(negedge i_Clock);
        chk("t1_ready_a", 32'(o_ReadyA),      32'd1);
        chk("t1_ready_b", 32'(o_ReadyB),      32'd0);
        chk("t1_we0",     32'(o_WriteEnable), 32'd0);
        tick();
        i_ValidA  = 1'b0;
        i_QueryRS = 5'd5;
        @(negedge i_Clock);
        chk("t1_we1",  32'(o_WriteEnable), 32'd1);
        chk("t1_rd",   32'(o_RD),          32'd5);
        chk("t1_d",    o_D,                32'h1234);
        chk("t1_hit",  32'(o_FwdHit),      32'd1);
        chk("t1_fwd",  o_FwdData,          32'h1234);
        tick();
        i_QueryRS = 5'd0;
        @(negedge i_Clock);
        chk("t1_we_after", 32'(o_WriteEnable), 32'd0);
        chk("t1_rd_after", 32'(o_RD),          32'd0);
        tick();

        // Both producers valid every cycle: grants A,B,A,B; writes follow.
        i_ValidA = 1'b1; i_RDA = 5'd1;  i_DA = 32'hA000_0001;
        i_ValidB = 1'b1; i_RDB = 5'd17; i_DB = 32'hB000_0011;
        @(negedge i_Clock);
        chk("rr0_ready_a", 32'(o_ReadyA),      32'd1);
        chk("rr0_ready_b", 32'(o_ReadyB),      32'd0);
        chk("rr0_we",      32'(o_WriteEnable), 32'd0);
        tick();
        i_RDA = 5'd2; i_DA = 32'hA000_0002;
        @(negedge i_Clock);
        chk("rr1_ready_a", 32'(o_ReadyA),      32'd0);
        chk("rr1_ready_b", 32'(o_ReadyB),      32'd1);
        chk("rr1_we",      32'(o_WriteEnable), 32'd1);
        chk("rr1_rd",      32'(o_RD),          32'd1);
        chk("rr1_d",       o_D,                32'hA000_0001);
        tick();
        i_RDB = 5'd18; i_DB = 32'hB000_0012;
        @(negedge i_Clock);
        chk("rr2_ready_a", 32'(o_ReadyA), 32'd1);
        chk("rr2_ready_b", 32'(o_ReadyB), 32'd0);
        chk("rr2_rd",      32'(o_RD),     32'd17);
        chk("rr2_d",       o_D,           32'hB000_0011);
        tick();
        i_RDA = 5'd3; i_DA = 32'hA000_0003;
        @(negedge i_Clock);
        chk("rr3_ready_a", 32'(o_ReadyA), 32'd0);
        chk("rr3_ready_b", 32'(o_ReadyB), 32'd1);
        chk("rr3_rd",      32'(o_RD),     32'd2);
        tick();
        i_ValidA = 1'b0;
        i_ValidB = 1'b0;
        @(negedge i_Clock);
        chk("rr4_we", 32'(o_WriteEnable), 32'd1);
        chk("rr4_rd", 32'(o_RD),          32'd18);
        tick();
        @(negedge i_Clock);
        chk("rr5_we", 32'(o_WriteEnable), 32'd0);
        tick();

        // Stalled fill to full, forwarding, then drain at one write per cycle.
        i_Stall = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            i_ValidA = 1'b1;
            i_RDA    = 5'(r);
            i_DA     = 32'hC0 + 32'(r);
            @(negedge i_Clock);
            chk("fill_ready_a", 32'(o_ReadyA),      32'd1);
            chk("fill_we",      32'(o_WriteEnable), 32'd0);
            tick();
        end
        i_RDA     = 5'd5;
        i_DA      = 32'hC5;
        i_QueryRS = 5'd3;
        @(negedge i_Clock);
        chk("full_ready_a", 32'(o_ReadyA), 32'd0);
        chk("full_head_rd", 32'(o_RD),     32'd1);
        chk("full_hit",     32'(o_FwdHit), 32'd1);
        chk("full_fwd",     o_FwdData,     32'hC3);
        tick();
        i_Stall   = 1'b0;
        i_QueryRS = 5'd9;
        @(negedge i_Clock);
        chk("deqfull_ready_a", 32'(o_ReadyA),      32'd0);
        chk("deqfull_we",      32'(o_WriteEnable), 32'd1);
        chk("deqfull_rd",      32'(o_RD),          32'd1);
        chk("miss_hit",        32'(o_FwdHit),      32'd0);
        chk("miss_fwd",        o_FwdData,          32'd0);
        tick();
        i_ValidA = 1'b0;
        for (int r = 2; r <= 4; r++) begin
            @(negedge i_Clock);
            chk("drain_we", 32'(o_WriteEnable), 32'd1);
            chk("drain_rd", 32'(o_RD),          32'(r));
            chk("drain_d",  o_D,                32'hC0 + 32'(r));
            tick();
        end
        @(negedge i_Clock);
        chk("drained_we", 32'(o_WriteEnable), 32'd0);
        tick();

        // Write to x0: accepted, never queued, never forwarded.
        i_ValidA  = 1'b1;
        i_RDA     = 5'd0;
        i_DA      = 32'hFFFF_FFFF;
        i_QueryRS = 5'd0;
        @(negedge i_Clock);
        chk("x0_ready_a", 32'(o_ReadyA), 32'd1);
        chk("x0_hit",     32'(o_FwdHit), 32'd0);
        chk("x0_fwd",     o_FwdData,     32'd0);
        tick();
        i_ValidA = 1'b0;
        @(negedge i_Clock);
        chk("x0_we",  32'(o_WriteEnable), 32'd0);
        chk("x0_rd",  32'(o_RD),          32'd0);
        chk("x0_d",   o_D,                32'd0);
        tick();

        // Two writes to r7 under stall: youngest wins, same-cycle input ignored.
        i_Stall  = 1'b1;
        i_ValidA = 1'b1;
        i_RDA    = 5'd7;
        i_DA     = 32'hA;
        @(negedge i_Clock);
        chk("r7a_ready_a", 32'(o_ReadyA), 32'd1);
        tick();
        i_ValidA  = 1'b0;
        i_ValidB  = 1'b1;
        i_RDB     = 5'd7;
        i_DB      = 32'hB;
        i_QueryRS = 5'd7;
        @(negedge i_Clock);
        chk("r7b_ready_b",   32'(o_ReadyB), 32'd1);
        chk("r7_same_cycle", o_FwdData,     32'hA);
        tick();
        i_ValidB = 1'b0;
        @(negedge i_Clock);
        chk("r7_hit",   32'(o_FwdHit), 32'd1);
        chk("r7_young", o_FwdData,     32'hB);
        chk("r7_head",  o_D,           32'hA);
        tick();

        // Reset mid-operation with stall released: pending entries must vanish.
        i_Reset  = 1'b0;
        i_Stall  = 1'b0;
        i_ValidA = 1'b1; i_RDA = 5'd3; i_DA = 32'h33;
        i_ValidB = 1'b1; i_RDB = 5'd4; i_DB = 32'h44;
        @(negedge i_Clock);
        chk("mrst_we_during", 32'(o_WriteEnable), 32'd0);
        chk("mrst_ready_a",   32'(o_ReadyA),      32'd0);
        chk("mrst_ready_b",   32'(o_ReadyB),      32'd0);
        tick();
        @(negedge i_Clock);
        chk("mrst_we",  32'(o_WriteEnable), 32'd0);
        chk("mrst_hit", 32'(o_FwdHit),      32'd0);
        chk("mrst_fwd", o_FwdData,          32'd0);
        chk("mrst_rd",  32'(o_RD),          32'd0);
        chk("mrst_d",   o_D,                32'd0);
        tick();

        // After reset, priority is back at A for a contested request.
        i_Reset = 1'b1;
        @(negedge i_Clock);
        chk("post_ready_a", 32'(o_ReadyA),      32'd1);
        chk("post_ready_b", 32'(o_ReadyB),      32'd0);
        chk("post_we",      32'(o_WriteEnable), 32'd0);
        tick();
        i_ValidA = 1'b0;
        i_ValidB = 1'b0;
        @(negedge i_Clock);
        chk("post_we1", 32'(o_WriteEnable), 32'd1);
        chk("post_rd",  32'(o_RD),          32'd3);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entry count (power of two, >= 2).
REQ-002 SHALL have port i_Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_Reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports i_ValidA / i_ValidB  input  1  producer A (ALU) / producer B (LSU) result valid.
REQ-005 SHALL have ports i_RDA / i_RDB  input  5  destination register of A / B.
REQ-006 SHALL have ports i_DA / i_DB  input  32  result data of A / B.
REQ-007 SHALL have ports o_ReadyA / o_ReadyB  output  1  accept strobe to A / B.
REQ-008 SHALL have port i_Stall  input  1  register-file write port unavailable this cycle.
REQ-009 SHALL have ports o_WriteEnable  output  1, o_RD  output  5, o_D  output  32  drive the register-file write port.
REQ-010 SHALL have ports i_QueryRS  input  5, o_FwdHit  output  1, o_FwdData  output  32  pending-write lookup.

Function
REQ-011 Transfer on a producer port SHALL occur in a cycle where its valid and ready are both high; at most one transfer per cycle.
REQ-012 o_ReadyA/o_ReadyB SHALL depend only on registered state and the valids, never on i_Stall; no ready when count == DEPTH.
REQ-013 Arbitration SHALL be round-robin: a priority bit (reset to A) selects the winner when both valid; it flips to the loser after every two-way-contested grant; a lone valid always wins when not full.
REQ-014 A transfer with RD == 0 SHALL be accepted (ready high) but not enqueued.
REQ-015 Head entry SHALL drive o_RD/o_D whenever count > 0; o_WriteEnable = (count > 0) && !i_Stall; an entry dequeues exactly when o_WriteEnable is high.
REQ-016 Minimum latency SHALL be one cycle: a transfer at edge N appears on o_WriteEnable in cycle N+1 if the queue was empty and unstalled.
REQ-017 Simultaneous enqueue and dequeue SHALL leave count unchanged; ready is withheld when full even if a dequeue occurs that cycle.
REQ-018 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-019 Write order SHALL equal acceptance order; no entry coalescing.
REQ-020 o_FwdHit SHALL be high, combinationally, when any occupied entry has RD == i_QueryRS and i_QueryRS != 0; o_FwdData SHALL be the youngest matching entry's data; else o_FwdData = 0.
REQ-021 Forwarding SHALL not include the same-cycle incoming transfer.

Reset
REQ-022 While i_Reset is low at a clock edge, count, pointers and priority bit SHALL clear (priority to A); entry contents need not clear.
REQ-023 During and after reset, o_WriteEnable, o_ReadyA, o_ReadyB, o_FwdHit SHALL be 0 and o_RD, o_D, o_FwdData SHALL be 0 until the first enqueue.
REQ-024 Reset mid-operation SHALL discard all pending entries without issuing writes.

Structure
REQ-025 A shared package SHALL hold the writeback entry struct (rd 5b, data 32b), register-index width 5 and data width 32 constants.
REQ-026 One sub-module, writeback_arbiter (2-way round-robin, grant + priority flop), is natural; FIFO storage stays in writeback_queue.

Verification
REQ-027 Reset low 2 cycles, then A valid RD=5 D=0x1234 -> ReadyA=1; next cycle WriteEnable=1, RD=5, D=0x1234.
REQ-028 A and B valid every cycle (A RD=1.., B RD=17..), no stall -> grants alternate A,B,A,B; writes in that order.
REQ-029 i_Stall=1, A pushes RD=1..4 -> ReadyA=0 on 5th; Query=3 -> Hit=1, data 3rd; Stall=0 -> 4 writes in 4 cycles.
REQ-030 A RD=0 D=0xFFFF_FFFF -> ReadyA=1, no write ever issued, count stays 0; Query=0 -> Hit=0.
REQ-031 Two entries RD=7 (0xA then 0xB) stalled -> Query=7 gives 0xB; assert reset -> next cycle WriteEnable=0, Hit=0.
